// File: rtl/spi_ll_pkg.sv
// Shared definitions for the byte-level SPI master: state encoding and startup length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_ll_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      HOLD    = 2'd2,
      STARTUP = 2'd3
   } state_t;

   // Number of full SCK cycles clocked out with CS high after reset
   // when the startup sequence is compiled in.
   localparam int STARTUP_SCK_CYCLES = 80;

endpackage

// File: rtl/spi_ll_byte_ckgen.sv
// SCK divider: one-cycle tick every N+1 clocks, counter reloads to N on each tick.
// Latency: first tick N+1 clocks after restart is released.
// Backpressure: none; free-running, restart re-phases the count.
module spi_ckgen (
   input  logic       i_clk,
   input  logic [7:0] i_n,
   input  logic       i_restart,
   output logic       o_tick
);

   logic [7:0] r_cnt;

   // A restart always wins so the first half-period after it is a full N+1 clocks.
   assign o_tick = (r_cnt == 8'd0) && !i_restart;

   // Down-counter: reload on restart or on the tick, otherwise count down.
   always_ff @(posedge i_clk) begin
      if (i_restart || (r_cnt == 8'd0)) begin
         r_cnt <= i_n;
      end else begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

endmodule

// File: rtl/spi_ll_byte.sv
// SPI mode-0 byte shifter with CS hold between bytes; optional 80-cycle SCK startup (SPI_STARTUP_EN).
// Latency: o_stb 16*(N+1)+1 clocks after the accept cycle; CS released N+1 clocks after o_stb if idle.
// Backpressure: i_stb accepted only when !o_busy (IDLE or HOLD); o_busy stays high for the whole byte.
module spi_ll_byte
   import spi_ll_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_ckspd,
   input  logic       i_stb,
   input  logic [7:0] i_byte,
   output logic       o_busy,
   output logic       o_stb,
   output logic [7:0] o_byte,
   output logic       o_sck,
   output logic       o_cs_n,
   output logic       o_mosi,
   input  logic       i_miso
);

`ifdef SPI_STARTUP_EN
   localparam state_t RST_STATE = STARTUP;
   localparam logic   RST_BUSY  = 1'b1;
`else
   localparam state_t RST_STATE = IDLE;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   state_t     r_state, w_state_nxt;
   logic       r_sck, r_cs_n, r_mosi, r_stb, r_busy;
   logic       w_sck_nxt, w_cs_n_nxt, w_mosi_nxt, w_stb_nxt, w_busy_nxt;
   logic [7:0] r_byte, r_tx, r_rx, r_n;
   logic [7:0] w_byte_nxt, w_tx_nxt, w_rx_nxt, w_n_nxt;
   logic [2:0] r_bit, w_bit_nxt;
`ifdef SPI_STARTUP_EN
   logic [6:0] r_su_cnt, w_su_cnt_nxt;
`endif

   logic       w_accept, w_restart, w_tick, w_rise, w_fall;
   logic [7:0] w_n;

   // The divider value is taken live on restart and from the latched copy otherwise,
   // so N cannot change in the middle of a byte.
   assign w_accept  = i_stb && !r_busy && ((r_state == IDLE) || (r_state == HOLD));
   assign w_restart = i_reset || w_accept;
   assign w_n       = w_restart ? i_ckspd : r_n;
   assign w_rise    = w_tick && !r_sck;
   assign w_fall    = w_tick && r_sck;

   spi_ckgen u_ckgen (
      .i_clk     (i_clk),
      .i_n       (w_n),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= RST_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      w_state_nxt = r_state;
      w_sck_nxt   = r_sck;
      w_cs_n_nxt  = r_cs_n;
      w_mosi_nxt  = r_mosi;
      w_stb_nxt   = 1'b0;
      w_busy_nxt  = r_busy;
      w_byte_nxt  = r_byte;
      w_tx_nxt    = r_tx;
      w_rx_nxt    = r_rx;
      w_n_nxt     = r_n;
      w_bit_nxt   = r_bit;
`ifdef SPI_STARTUP_EN
      w_su_cnt_nxt = r_su_cnt;
`endif
      case (r_state)
         IDLE, HOLD: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_busy_nxt  = 1'b1;
               w_cs_n_nxt  = 1'b0;
               w_sck_nxt   = 1'b0;
               w_mosi_nxt  = i_byte[7];
               w_tx_nxt    = i_byte;
               w_n_nxt     = i_ckspd;
               w_bit_nxt   = 3'd0;
            end else if ((r_state == HOLD) && w_tick) begin
               w_state_nxt = IDLE;
               w_cs_n_nxt  = 1'b1;
            end
         end
         SHIFT: begin
            if (w_rise) begin
               w_sck_nxt = 1'b1;
               w_rx_nxt  = {r_rx[6:0], i_miso};
            end
            if (w_fall) begin
               w_sck_nxt = 1'b0;
               if (r_bit == 3'd7) begin
                  // Last falling edge: hand the byte out and park in HOLD with CS low.
                  w_bit_nxt   = 3'd0;
                  w_state_nxt = HOLD;
                  w_stb_nxt   = 1'b1;
                  w_byte_nxt  = r_rx;
                  w_busy_nxt  = 1'b0;
                  w_mosi_nxt  = 1'b1;
               end else begin
                  w_bit_nxt  = r_bit + 3'd1;
                  w_tx_nxt   = {r_tx[6:0], 1'b0};
                  w_mosi_nxt = r_tx[6];
               end
            end
         end
`ifdef SPI_STARTUP_EN
         STARTUP: begin
            if (w_tick) begin
               w_sck_nxt = !r_sck;
            end
            if (w_fall) begin
               if (r_su_cnt == 7'(STARTUP_SCK_CYCLES - 1)) begin
                  w_su_cnt_nxt = 7'd0;
                  w_state_nxt  = IDLE;
                  w_busy_nxt   = 1'b0;
               end else begin
                  w_su_cnt_nxt = r_su_cnt + 7'd1;
               end
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_cs_n_nxt  = 1'b1;
            w_sck_nxt   = 1'b0;
            w_mosi_nxt  = 1'b1;
         end
      endcase
   end

   // Output and datapath registers; reset aborts any byte without a strobe.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sck  <= 1'b0;
         r_cs_n <= 1'b1;
         r_mosi <= 1'b1;
         r_stb  <= 1'b0;
         r_busy <= RST_BUSY;
         r_byte <= 8'hff;
         r_tx   <= 8'h00;
         r_rx   <= 8'h00;
         r_n    <= i_ckspd;
         r_bit  <= 3'd0;
`ifdef SPI_STARTUP_EN
         r_su_cnt <= 7'd0;
`endif
      end else begin
         r_sck  <= w_sck_nxt;
         r_cs_n <= w_cs_n_nxt;
         r_mosi <= w_mosi_nxt;
         r_stb  <= w_stb_nxt;
         r_busy <= w_busy_nxt;
         r_byte <= w_byte_nxt;
         r_tx   <= w_tx_nxt;
         r_rx   <= w_rx_nxt;
         r_n    <= w_n_nxt;
         r_bit  <= w_bit_nxt;
`ifdef SPI_STARTUP_EN
         r_su_cnt <= w_su_cnt_nxt;
`endif
      end
   end

   assign o_sck  = r_sck;
   assign o_cs_n = r_cs_n;
   assign o_mosi = r_mosi;
   assign o_stb  = r_stb;
   assign o_busy = r_busy;
   assign o_byte = r_byte;

endmodule
